// File: rtl/regfile_access_arbiter_pkg.sv
// Shared definitions for the register-file access arbiter.
//   state_e        : arbiter FSM encoding (IDLE=00, ACCESS=01, RESP=10)
//   RF_DATA_WIDTH  : default register data width
//   RF_ADDR_WIDTH  : default register address width
//   idx_width()    : width of a requester index for a given requester count
package regfile_access_arbiter_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// Requester-side bus of the register-file access arbiter.
//   req        : per-requester transaction request
//   req_wr     : per-requester op, 1 = write, 0 = read pair
//   req_addr_a : read address A, slice i belongs to requester i
//   req_addr_b : read address B
//   req_addr_w : write address
//   req_data_w : write data
//   gnt        : one-hot grant, high while the transaction owns the register file
//   ack        : one-hot single-cycle completion pulse
//   rd_data_a  : registered read data A, valid from ack until the next read
//   rd_data_b  : registered read data B
// Modports: master = requesters, slave = arbiter.
interface regfile_access_arbiter_if
  import regfile_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_a;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_b;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_w;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_w;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]         rd_data_a;
  logic [DATA_WIDTH-1:0]         rd_data_b;

  modport master (
    output req, req_wr, req_addr_a, req_addr_b, req_addr_w, req_data_w,
    input  gnt, ack, rd_data_a, rd_data_b
  );

  modport slave (
    input  req, req_wr, req_addr_a, req_addr_b, req_addr_w, req_data_w,
    output gnt, ack, rd_data_a, rd_data_b
  );

endinterface

// File: rtl/regfile_access_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// ptr (wrapping) wins.
//   req        : request vector
//   ptr        : index of the highest-priority requester
//   winner_oh  : one-hot winner, all zero when no request
//   winner_idx : winner index, zero when no request
module rr_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    cand       = '0;
    found      = 1'b0;
    // Walk the requesters starting at ptr; the first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found           = 1'b1;
        winner_oh[cand] = 1'b1;
        winner_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares one 2-read/1-write register file among NUM_REQ requesters.
// Round-robin arbitration, one transaction at a time: IDLE -> ACCESS -> RESP.
//   clk, rst    : clock; synchronous active-low reset
//   bus         : requester bus (slave modport)
//   busy        : high whenever the FSM is not in IDLE
//   rf_read     : register file READ strobe (ACCESS, read op)
//   rf_write    : register file WRITE strobe (ACCESS, write op)
//   rf_addr_r1  : read address A, rf_addr_r2 : read address B
//   rf_addr_w   : write address, rf_data_w : write data
//   rf_data_r1  : read data A, rf_data_r2 : read data B (float when rf_read=0)
// Build option REGFILE_R0_HARDWIRE_EN: register 0 reads as zero and writes to
// it are dropped (the transaction still acknowledges).
module regfile_access_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_access_arbiter_if.slave bus,
  output logic                    busy,
  output logic                    rf_read,
  output logic                    rf_write,
  output logic [ADDR_WIDTH-1:0]   rf_addr_r1,
  output logic [ADDR_WIDTH-1:0]   rf_addr_r2,
  output logic [ADDR_WIDTH-1:0]   rf_addr_w,
  output logic [DATA_WIDTH-1:0]   rf_data_w,
  input  logic [DATA_WIDTH-1:0]   rf_data_r1,
  input  logic [DATA_WIDTH-1:0]   rf_data_r2
);

  localparam int IDX_W = idx_width(NUM_REQ);

  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [DATA_WIDTH-1:0] data_w;
  } txn_t;

  state_e                state, state_next;
  txn_t                  txn;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      arb_idx;
  logic [NUM_REQ-1:0]    arb_oh;
  logic                  arb_valid;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic                  wr_suppress, zero_a, zero_b;

  logic [ADDR_WIDTH-1:0] addr_a_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_b_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_w_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_w_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a_arr[g] = bus.req_addr_a[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_b_arr[g] = bus.req_addr_b[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_w_arr[g] = bus.req_addr_w[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_w_arr[g] = bus.req_data_w[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req        (bus.req),
    .ptr        (ptr),
    .winner_oh  (arb_oh),
    .winner_idx (arb_idx)
  );

  assign arb_valid = |arb_oh;

`ifdef REGFILE_R0_HARDWIRE_EN
  assign wr_suppress = (txn.addr_w == '0);
  assign zero_a      = (txn.addr_a == '0);
  assign zero_b      = (txn.addr_b == '0);
`else
  assign wr_suppress = 1'b0;
  assign zero_a      = 1'b0;
  assign zero_b      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked logic so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (arb_valid) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Transaction capture: requester fields are frozen here, so later changes
  // on the bus (including a dropped req) do not affect the transaction.
  always_ff @(posedge clk) begin
    // NOTE: deliberately no reset; these fields are only observed in
    // ACCESS/RESP, and ACCESS is always entered through this load in IDLE.
    if (state == ST_IDLE && arb_valid) begin
      txn.idx    <= arb_idx;
      txn.wr     <= bus.req_wr[arb_idx];
      txn.addr_a <= addr_a_arr[arb_idx];
      txn.addr_b <= addr_b_arr[arb_idx];
      txn.addr_w <= addr_w_arr[arb_idx];
      txn.data_w <= data_w_arr[arb_idx];
    end
  end

  // Round-robin pointer and read-data registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr  <= '0;
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      if (state == ST_RESP)
        ptr <= (txn.idx == IDX_W'(NUM_REQ - 1)) ? '0 : txn.idx + 1'b1;
      if (state == ST_ACCESS && !txn.wr) begin
        rd_a <= zero_a ? '0 : rf_data_r1;
        rd_b <= zero_b ? '0 : rf_data_r2;
      end
    end
  end

  // Output logic.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    bus.gnt    = '0;
    bus.ack    = '0;
    rf_read    = 1'b0;
    rf_write   = 1'b0;
    rf_addr_r1 = '0;
    rf_addr_r2 = '0;
    rf_addr_w  = '0;
    rf_data_w  = '0;
    unique case (state)
      ST_ACCESS: begin
        bus.gnt[txn.idx] = 1'b1;
        rf_addr_r1       = txn.addr_a;
        rf_addr_r2       = txn.addr_b;
        rf_addr_w        = txn.addr_w;
        rf_data_w        = txn.data_w;
        rf_read          = !txn.wr;
        rf_write         = txn.wr && !wr_suppress;
      end
      ST_RESP: bus.ack[txn.idx] = 1'b1;
      default: ;
    endcase
  end

  assign busy          = (state != ST_IDLE);
  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;

endmodule
